// File: rtl/dmem_bridge.sv
// Bridges the CPU's single-cycle data-RAM port to a req/ack data memory and stalls the pipeline while an access is in flight.
// Optional build macro: DMEM_TIMEOUT_EN adds a watchdog that aborts a request after MAX_WAIT cycles and raises a sticky err_o.
module dmem_bridge #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [31:0] ram_addr_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT - 1);

    state_e      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_sel_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        unused_ok;

    // A store with no byte lanes selected is a no-op and must not stall the pipeline.
    assign accept     = ram_ce_i && !(ram_we_i && (ram_sel_i == 4'b0000));
    assign stallreq_o = ((state_q == IDLE) && accept) || (state_q == REQ);

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign err_o     = err_q;
    assign unused_ok = &{1'b0, ram_addr_i[1:0]};
`else
    assign err_o     = 1'b0;
    assign unused_ok = &{1'b0, ram_addr_i[1:0], ^MAX_CNT};
`endif

    // NOTE: every register here is a plain flop, so all of them take the synchronous reset and use <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_sel_q   <= 4'h0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mem_we_q    <= ram_we_i;
                        mem_addr_q  <= {ram_addr_i[31:2], 2'b00};
                        mem_sel_q   <= (ram_sel_i == 4'b0000) ? 4'b1111 : ram_sel_i;
                        mem_wdata_q <= ram_data_i;
                        mem_req_q   <= 1'b1;
                        state_q     <= REQ;
`ifdef DMEM_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    // An ack in the same cycle as expiry takes the branch above and completes normally.
                    else if (cnt_q == MAX_CNT) begin
                        if (!mem_we_q) begin
                            rdata_q <= 32'h0;
                        end
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_data_o  = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: load/store handshakes, back-to-back, no-op store, stray ack, reset mid-request, watchdog.
// Expected load data is queued when an access is issued and popped in the DONE cycle.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ce_i;
    logic        ram_we_i;
    logic [31:0] ram_addr_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    dmem_bridge #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_ce_i    (ram_ce_i),
        .ram_we_i    (ram_we_i),
        .ram_addr_i  (ram_addr_i),
        .ram_sel_i   (ram_sel_i),
        .ram_data_i  (ram_data_i),
        .ram_data_o  (ram_data_o),
        .stallreq_o  (stallreq_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_sel_o   (mem_sel_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access: IDLE cycle, waits+1 REQ cycles (ack on the last), then the DONE cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                          input logic hold_ce, input string name);
        logic [3:0] exp_sel;
        int         stalls;
        int         reqs;
        exp_sel = (sel == 4'b0000) ? 4'b1111 : sel;
        stalls  = 0;
        reqs    = 0;
        @(negedge clk);
        ram_ce_i   = 1'b1;
        ram_we_i   = we;
        ram_addr_i = addr;
        ram_sel_i  = sel;
        ram_data_i = wdata;
        mem_ack_i  = 1'b0;
        #1;
        check({name, "_idle_stall"}, 32'(stallreq_o), 32'd1);
        check({name, "_idle_req"}, 32'(mem_req_o), 32'd0);
        stalls += int'(stallreq_o);
        exp_q.push_back(we ? model_rdata : rdata);
        if (!we) model_rdata = rdata;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            mem_ack_i   = (i == waits);
            mem_rdata_i = (i == waits) ? rdata : (32'hBAD0_0000 + 32'(i));
            #1;
            stalls += int'(stallreq_o);
            reqs   += int'(mem_req_o);
            check({name, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
            check({name, "_sel"}, 32'(mem_sel_o), 32'(exp_sel));
            check({name, "_we"}, 32'(mem_we_o), 32'(we));
            if (we) check({name, "_wdata"}, mem_wdata_o, wdata);
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        ram_ce_i  = hold_ce;
        #1;
        check({name, "_done_stall"}, 32'(stallreq_o), 32'd0);
        check({name, "_done_req"}, 32'(mem_req_o), 32'd0);
        check({name, "_rdata"}, ram_data_o, exp_q.pop_front());
        check({name, "_stall_cycles"}, 32'(stalls), 32'(waits + 2));
        check({name, "_req_cycles"}, 32'(reqs), 32'(waits + 1));
    endtask

    initial begin
        rst         = 1'b1;
        ram_ce_i    = 1'b0;
        ram_we_i    = 1'b0;
        ram_addr_i  = 32'h0;
        ram_sel_i   = 4'h0;
        ram_data_i  = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdata", ram_data_o, 32'h0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_sel", 32'(mem_sel_o), 32'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        rst = 1'b0;

        access(1'b0, 32'h0000_1006, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, "ld0");
        access(1'b1, 32'h0000_2000, 4'b0011, 32'h1234_5678, 32'hCAFE_0000, 3, 1'b0, "st3");
        access(1'b0, 32'h0000_3008, 4'b1111, 32'h0, 32'h1111_2222, 1, 1'b1, "b2b_a");
        access(1'b0, 32'h0000_300C, 4'b1111, 32'h0, 32'h3333_4444, 0, 1'b0, "b2b_b");

        // Store with no byte lanes: no request, no stall.
        @(negedge clk);
        ram_ce_i  = 1'b1;
        ram_we_i  = 1'b1;
        ram_sel_i = 4'b0000;
        #1;
        check("nop_st_stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        ram_ce_i = 1'b0;
        #1;
        check("nop_st_req", 32'(mem_req_o), 32'd0);
        check("nop_st_stall2", 32'(stallreq_o), 32'd0);

        access(1'b0, 32'h0000_4001, 4'b0000, 32'h0, 32'h55AA_55AA, 2, 1'b0, "ld_sel0");

        // Stray ack while idle.
        @(negedge clk);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("stray_stall", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check("stray_req", 32'(mem_req_o), 32'd0);
        check("stray_rdata", ram_data_o, model_rdata);
        check("stray_stall2", 32'(stallreq_o), 32'd0);

        // Reset while in REQ, then a late ack.
        @(negedge clk);
        ram_ce_i   = 1'b1;
        ram_we_i   = 1'b0;
        ram_addr_i = 32'h0000_5000;
        ram_sel_i  = 4'b1111;
        @(negedge clk);
        ram_ce_i = 1'b0;
        #1;
        check("rstreq_req_before", 32'(mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 32'h0;
        #1;
        check("rstreq_req_after", 32'(mem_req_o), 32'd0);
        check("rstreq_stall", 32'(stallreq_o), 32'd0);
        check("rstreq_rdata", ram_data_o, 32'h0);
        @(negedge clk);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check("late_ack_req", 32'(mem_req_o), 32'd0);
        check("late_ack_rdata", ram_data_o, 32'h0);
        check("late_ack_stall", 32'(stallreq_o), 32'd0);

`ifdef DMEM_TIMEOUT_EN
        // Ack in the last allowed REQ cycle wins over the watchdog.
        access(1'b0, 32'h0000_6000, 4'b1111, 32'h0, 32'h9999_AAAA, 3, 1'b0, "ack_at_limit");
        check("ack_at_limit_err", 32'(err_o), 32'd0);

        @(negedge clk);
        ram_ce_i   = 1'b1;
        ram_we_i   = 1'b0;
        ram_addr_i = 32'h0000_7000;
        ram_sel_i  = 4'b1111;
        @(negedge clk);
        ram_ce_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("to_req_held", 32'(mem_req_o), 32'd1);
            check("to_err_early", 32'(err_o), 32'd0);
        end
        @(negedge clk);
        #1;
        check("to_done_req", 32'(mem_req_o), 32'd0);
        check("to_done_stall", 32'(stallreq_o), 32'd0);
        check("to_done_rdata", ram_data_o, 32'h0);
        check("to_done_err", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("to_err_sticky", 32'(err_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("to_err_cleared", 32'(err_o), 32'd0);
`else
        // Without the watchdog an unacked request stalls indefinitely.
        begin
            int stalls;
            stalls = 0;
            @(negedge clk);
            ram_ce_i   = 1'b1;
            ram_we_i   = 1'b0;
            ram_addr_i = 32'h0000_7000;
            ram_sel_i  = 4'b1111;
            @(negedge clk);
            ram_ce_i = 1'b0;
            for (int i = 0; i < 120; i++) begin
                @(negedge clk);
                #1;
                stalls += int'(stallreq_o);
            end
            check("no_to_stall_cycles", 32'(stalls), 32'd120);
            check("no_to_req_held", 32'(mem_req_o), 32'd1);
            check("no_to_err", 32'(err_o), 32'd0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("no_to_rst_req", 32'(mem_req_o), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the CPU core's single-cycle data-RAM port (ram_ce/we/addr/sel/data) and a multi-cycle data memory that uses a req/ack handshake.
- Registers each CPU access and drives it to memory, holding it stable until acknowledged.
- Asserts a stall request back to the pipeline while the access is in flight.
- Returns registered read data to the MEM stage in the cycle the stall drops.

Parameters:
MAX_WAIT, 255, cycles in REQ before watchdog abort (used only with DMEM_TIMEOUT_EN)
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ram_ce_i  in  1  CPU access enable
ram_we_i  in  1  1=store, 0=load
ram_addr_i  in  32  CPU byte address
ram_sel_i  in  4  byte-lane enables, bit0=bits[7:0]
ram_data_i  in  32  store data
ram_data_o  out  32  load data to CPU (registered)
stallreq_o  out  1  pipeline stall request (combinational)
mem_req_o  out  1  memory request valid
mem_we_o  out  1  memory write
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_sel_o  out  4  byte enables
mem_wdata_o  out  32  write data
mem_ack_i  in  1  memory done; read data valid same cycle
mem_rdata_i  in  32  memory read word
err_o  out  1  timeout flag (constant 0 without DMEM_TIMEOUT_EN)

Behaviour:

Reset:
- state=IDLE; mem_req_o, mem_we_o, err_o = 0.
- mem_addr_o, mem_sel_o, mem_wdata_o, ram_data_o = 0; wait counter = 0.
- Reset mid-transaction returns to IDLE at that edge; any mem_ack_i arriving afterwards is ignored.

FSM:
- IDLE:
  - If ram_ce_i=1 and sel!=0: latch we/addr/sel/wdata into the mem_* registers, set mem_req_o=1, go to REQ. stallreq_o=1 in this cycle.
  - If ram_ce_i=1, we=1, sel=0000: no-op, no request, stallreq_o=0, stay in IDLE.
  - A load with sel=0000 is treated as sel=1111.
- REQ:
  - mem_req_o=1; mem_* outputs held stable; stallreq_o=1.
  - On mem_ack_i=1: latch mem_rdata_i into ram_data_o (loads only; stores leave ram_data_o unchanged), drop mem_req_o, go to DONE.
- DONE:
  - stallreq_o=0 for exactly this one cycle, so the CPU consumes ram_data_o and advances.
  - Next state is IDLE unconditionally.
  - A new ram_ce_i seen in DONE is not accepted; it is accepted in the following IDLE cycle.

Timing and handshake:
- stallreq_o = (state==IDLE && ram_ce_i && !(ram_we_i && ram_sel_i==0)) || state==REQ.
- Latency with ack in the first REQ cycle: stall 2 cycles, data usable in the 3rd cycle (DONE). Each extra wait cycle adds 1.
- mem_ack_i outside REQ is ignored.
- If ram_ce_i drops during REQ (pipeline flush), the memory transaction still completes through DONE. The data is registered but unused.
- ram_data_o holds its value between loads.
- Bridge never issues a second request before the first is acked: single outstanding transaction.
- Unselected byte lanes of ram_data_o carry memory data unmodified; lane extraction and sign extension stay in the CPU.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - Wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches MAX_WAIT with no ack: drop mem_req_o, set ram_data_o=32'h0 for loads, set err_o=1, go to DONE.
  - err_o is sticky until rst.
  - An ack arriving in the same cycle as timeout wins: normal completion, no error.
- Without the macro:
  - No counter logic is built; err_o is tied 0.
  - REQ waits indefinitely for ack.

Test Plan:
- Load, ack on 1st REQ cycle: ce=1, we=0, addr=0x0000_1006, sel=1111, rdata=0xDEADBEEF → mem_addr_o=0x0000_1004; stallreq_o high 2 cycles; ram_data_o=0xDEADBEEF in DONE with stallreq_o=0.
- Store with 3 wait cycles: we=1, sel=0011, data=0x1234_5678 → mem_req_o high 4 cycles with mem_wdata_o/mem_sel_o stable; stall 5 cycles; exactly one request issued; ram_data_o unchanged.
- Back-to-back: two loads with ce held high → second mem_req_o rises 2 cycles after first ack (DONE, then IDLE); no overlap.
- Edge cases:
  - Store with sel=0000 → no mem_req_o, no stall.
  - Stray mem_ack_i while IDLE → no state change.
  - rst pulse during REQ → mem_req_o=0 next cycle; a later ack is ignored.
- Timeout (DMEM_TIMEOUT_EN, MAX_WAIT=4): load with ack never asserted → abort after 4 REQ cycles; ram_data_o=0 and err_o=1 in DONE; err_o stays 1 until rst. Without the macro, stall persists for 100+ cycles.
